melody_seq: RTL and testbench

//   Note sequencer that drives the square-wave tone generator's div input.

---
 rtl/melody_pkg.sv | 22 ++
 rtl/melody_seq_if.sv | 39 +++
 rtl/tick_prescaler.sv | 26 ++
 rtl/melody_seq.sv | 183 ++++++++++++++++++
 tb/tb_melody_seq.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/melody_pkg.sv
// melody_pkg: shared constants for the melody sequencer (state encoding,
// default widths, table-entry sentinels).
package melody_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // Default configuration
  localparam int unsigned DEF_WIDTH_COUNTER = 10;
  localparam int unsigned DEF_DEPTH         = 16;
  localparam int unsigned DEF_WIDTH_DUR     = 6;
  localparam int unsigned DEF_TICK_DIV      = 1000;
  localparam int unsigned DEF_GAP_TICKS     = 1;

  // Entry sentinels: a zero duration ends the sequence, a zero divider is a rest
  localparam int unsigned END_DUR  = 0;
  localparam int unsigned REST_DIV = 0;

endpackage

// File: rtl/melody_seq_if.sv
// melody_seq_if: host-side note-table/control bus and tone outputs of melody_seq.
// The loop input exists only when MELODY_SEQ_LOOP_EN is defined.
interface melody_seq_if
  import melody_pkg::*;
#(
  parameter int unsigned WIDTH_COUNTER = DEF_WIDTH_COUNTER,
  parameter int unsigned DEPTH         = DEF_DEPTH,
  parameter int unsigned WIDTH_DUR     = DEF_WIDTH_DUR
) ();
  localparam int unsigned AW = $clog2(DEPTH);

  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [WIDTH_COUNTER-1:0] wr_div;
  logic [WIDTH_DUR-1:0]     wr_dur;
  logic                     start;
  logic                     stop;
`ifdef MELODY_SEQ_LOOP_EN
  logic                     loop;
`endif
  logic [WIDTH_COUNTER-1:0] div;
  logic                     tone_en;
  logic                     busy;
  logic [AW-1:0]            note_idx;
  logic                     done;

`ifdef MELODY_SEQ_LOOP_EN
  modport master (output wr_en, wr_addr, wr_div, wr_dur, start, stop, loop,
                  input  div, tone_en, busy, note_idx, done);
  modport slave  (input  wr_en, wr_addr, wr_div, wr_dur, start, stop, loop,
                  output div, tone_en, busy, note_idx, done);
`else
  modport master (output wr_en, wr_addr, wr_div, wr_dur, start, stop,
                  input  div, tone_en, busy, note_idx, done);
  modport slave  (input  wr_en, wr_addr, wr_div, wr_dur, start, stop,
                  output div, tone_en, busy, note_idx, done);
`endif

endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: modulo-TICK_DIV counter; tick marks the terminal count while enabled.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(TICK_DIV - 1));

  // Free-running count, wrapping on the terminal value
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/melody_seq.sv
// melody_seq: plays a programmable {div, dur} note table into a tone generator,
// with a fixed silent gap after each note.
// Optional feature macro: MELODY_SEQ_LOOP_EN (adds bus.loop to repeat the sequence).
module melody_seq
  import melody_pkg::*;
#(
  parameter int unsigned WIDTH_COUNTER = DEF_WIDTH_COUNTER,
  parameter int unsigned DEPTH         = DEF_DEPTH,
  parameter int unsigned WIDTH_DUR     = DEF_WIDTH_DUR,
  parameter int unsigned TICK_DIV      = DEF_TICK_DIV,
  parameter int unsigned GAP_TICKS     = DEF_GAP_TICKS
) (
  input logic        clk,
  input logic        rst,
  melody_seq_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = WIDTH_COUNTER + WIDTH_DUR;
  localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  logic [1:0]               state, state_nxt;
  logic [AW-1:0]            idx, idx_nxt;
  logic [WIDTH_COUNTER-1:0] div_q, div_nxt;
  logic [WIDTH_DUR-1:0]     dur_q, dur_nxt;
  logic [WIDTH_DUR-1:0]     tcnt, tcnt_nxt;
  logic [GW-1:0]            gcnt, gcnt_nxt;
  logic                     tone_q, tone_nxt;
  logic                     done_q, done_nxt;
  logic                     busy_q, busy_nxt;
  logic                     pre_clr, tick, end_seq, loop_c;

  logic [EW-1:0]            mem [DEPTH];
  logic [EW-1:0]            rd_q;
  logic [WIDTH_COUNTER-1:0] rd_div;
  logic [WIDTH_DUR-1:0]     rd_dur;

`ifdef MELODY_SEQ_LOOP_EN
  assign loop_c = bus.loop;
`else
  assign loop_c = 1'b0;
`endif

  assign rd_div = rd_q[EW-1:WIDTH_DUR];
  assign rd_dur = rd_q[WIDTH_DUR-1:0];

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (state != ST_IDLE),
    .tick (tick)
  );

  // Note table: one write port, registered read addressed by the next index so LOAD sees entry[idx]
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= {bus.wr_div, bus.wr_dur};
    end
    rd_q <= mem[idx_nxt];
  end

  // Next-state and output decode
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    div_nxt   = div_q;
    dur_nxt   = dur_q;
    tcnt_nxt  = tcnt;
    gcnt_nxt  = gcnt;
    tone_nxt  = tone_q;
    done_nxt  = 1'b0;
    pre_clr   = 1'b0;
    end_seq   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_nxt = ST_LOAD;
          idx_nxt   = '0;
          pre_clr   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (rd_dur == WIDTH_DUR'(END_DUR)) begin
          end_seq = 1'b1;
        end else begin
          div_nxt   = rd_div;
          dur_nxt   = rd_dur;
          tcnt_nxt  = '0;
          tone_nxt  = (rd_div != WIDTH_COUNTER'(REST_DIV));
          state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (tcnt == dur_q - WIDTH_DUR'(1)) begin
            state_nxt = ST_GAP;
            tone_nxt  = 1'b0;
            gcnt_nxt  = '0;
          end else begin
            tcnt_nxt = tcnt + WIDTH_DUR'(1);
          end
        end
      end
      default: begin
        if (tick) begin
          if (gcnt == GW'(GAP_TICKS - 1)) begin
            if (idx == AW'(DEPTH - 1)) begin
              end_seq = 1'b1;
            end else begin
              idx_nxt   = idx + AW'(1);
              state_nxt = ST_LOAD;
            end
          end else begin
            gcnt_nxt = gcnt + GW'(1);
          end
        end
      end
    endcase

    // End of sequence: either restart from entry 0 or return to IDLE with a done pulse
    if (end_seq) begin
      div_nxt  = '0;
      tone_nxt = 1'b0;
      if (loop_c) begin
        state_nxt = ST_LOAD;
        idx_nxt   = '0;
      end else begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end
    end

    // Abort overrides everything, including a coincident natural end
    if (bus.stop && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      div_nxt   = '0;
      tone_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      div_q  <= '0;
      dur_q  <= '0;
      tcnt   <= '0;
      gcnt   <= '0;
      tone_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      idx    <= idx_nxt;
      div_q  <= div_nxt;
      dur_q  <= dur_nxt;
      tcnt   <= tcnt_nxt;
      gcnt   <= gcnt_nxt;
      tone_q <= tone_nxt;
      done_q <= done_nxt;
      busy_q <= busy_nxt;
    end
  end

  assign bus.div      = div_q;
  assign bus.tone_en  = tone_q;
  assign bus.busy     = busy_q;
  assign bus.note_idx = idx;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_melody_seq.sv
// tb_melody_seq: directed stimulus with a scoreboard of expected tone runs and done pulses.
// A note with dur d sounds for d*TICK_DIV-1 cycles (the LOAD cycle completes its slot);
// busy length before done = sum over notes of (d+GAP_TICKS)*TICK_DIV plus one per terminator LOAD.
module tb_melody_seq;

  localparam int unsigned WC = 10;
  localparam int unsigned DP = 4;
  localparam int unsigned WD = 6;
  localparam int unsigned TD = 4;
  localparam int unsigned GT = 1;

  typedef struct { int div; int len; int idx; } run_t;
  typedef struct { int idx; int blen; } done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  melody_seq_if #(.WIDTH_COUNTER(WC), .DEPTH(DP), .WIDTH_DUR(WD)) bus ();

  melody_seq #(
    .WIDTH_COUNTER(WC), .DEPTH(DP), .WIDTH_DUR(WD), .TICK_DIV(TD), .GAP_TICKS(GT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  run_t  exp_runs[$];
  done_t exp_done[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: measures tone runs and busy length, compares against the scoreboard
  bit   run_on = 0;
  int   run_len, run_div, run_idx;
  int   run_cnt = 0;
  bit   busy_prev = 0;
  int   busy_len = 0;
  run_t er;
  done_t ed;

  always @(negedge clk) begin
    if (rst) begin
      run_on    = 0;
      busy_prev = 0;
      busy_len  = 0;
    end else begin
      if (bus.busy) busy_len = busy_prev ? busy_len + 1 : 1;
      busy_prev = bus.busy;
      if (bus.tone_en) begin
        if (!run_on) begin
          run_on  = 1;
          run_len = 1;
          run_div = int'(bus.div);
          run_idx = int'(bus.note_idx);
        end else begin
          run_len++;
        end
      end else if (run_on) begin
        run_on = 0;
        run_cnt++;
        chk("run_expected", int'(exp_runs.size() > 0), 1);
        if (exp_runs.size() > 0) begin
          er = exp_runs.pop_front();
          chk("run_div", run_div, er.div);
          chk("run_len", run_len, er.len);
          chk("run_idx", run_idx, er.idx);
        end
      end
      if (bus.done) begin
        chk("done_expected", int'(exp_done.size() > 0), 1);
        chk("done_busy_low", int'(bus.busy), 0);
        if (exp_done.size() > 0) begin
          ed = exp_done.pop_front();
          chk("done_note_idx", int'(bus.note_idx), ed.idx);
          chk("done_busy_len", busy_len, ed.blen);
        end
      end
    end
  end

  task automatic wr(input int a, input int d, input int t);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'(a);
    bus.wr_div  = 10'(d);
    bus.wr_dur  = 6'(t);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic push_run(input int d, input int l, input int i);
    run_t r;
    r.div = d; r.len = l; r.idx = i;
    exp_runs.push_back(r);
  endtask

  task automatic push_done(input int i, input int b);
    done_t r;
    r.idx = i; r.blen = b;
    exp_done.push_back(r);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!bus.busy && exp_runs.size() == 0 && exp_done.size() == 0) break;
    end
    chk({name, "_busy_end"}, int'(bus.busy), 0);
    chk({name, "_runs_left"}, exp_runs.size(), 0);
    chk({name, "_done_left"}, exp_done.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_tone_idx(input string name, input int i);
    bit ok = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (bus.tone_en && int'(bus.note_idx) == i) begin ok = 1; break; end
    end
    chk(name, int'(ok), 1);
  endtask

  initial begin
    bit ok;
    int base;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_div = '0; bus.wr_dur = '0;
    bus.start = 0; bus.stop = 0;
`ifdef MELODY_SEQ_LOOP_EN
    bus.loop = 0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_div", int'(bus.div), 0);
    chk("rst_tone_en", int'(bus.tone_en), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_note_idx", int'(bus.note_idx), 0);
    chk("rst_done", int'(bus.done), 0);

    // 1: note, rest, note, terminator
    wr(0, 50, 2); wr(1, 0, 1); wr(2, 30, 1); wr(3, 777, 0);
    push_run(50, 7, 0); push_run(30, 3, 2); push_done(3, 29);
    pulse_start();
    wait_idle("t1");
    chk("t1_div_after", int'(bus.div), 0);

    // 2: immediate terminator
    wr(0, 99, 0);
    push_done(0, 1);
    pulse_start();
    wait_idle("t2");

    // 3: full table without terminator ends after the last entry
    wr(0, 11, 1); wr(1, 22, 1); wr(2, 33, 1); wr(3, 44, 1);
    push_run(11, 3, 0); push_run(22, 3, 1); push_run(33, 3, 2); push_run(44, 3, 3);
    push_done(3, 32);
    pulse_start();
    wait_idle("t3");

    // 4: stop in PLAY of idx 1, then start+stop together in IDLE
    wr(0, 40, 2); wr(1, 60, 2); wr(2, 70, 1); wr(3, 0, 0);
    push_run(40, 7, 0); push_run(60, 1, 1);
    pulse_start();
    wait_tone_idx("t4_reach_idx1", 1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("t4_stop_busy", int'(bus.busy), 0);
    chk("t4_stop_tone", int'(bus.tone_en), 0);
    chk("t4_stop_div", int'(bus.div), 0);
    chk("t4_stop_done", int'(bus.done), 0);
    repeat (4) @(negedge clk);
    wait_idle("t4a");
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("t4_ss_busy0", int'(bus.busy), 0);
    @(negedge clk);
    chk("t4_ss_busy1", int'(bus.busy), 0);

    // 5a: rewrite entry 0 while it plays
    wr(0, 90, 2); wr(1, 0, 0);
    push_run(90, 7, 0); push_done(1, 13);
    pulse_start();
    wait_tone_idx("t5_reach_tone", 0);
    @(negedge clk);
    wr(0, 5, 2);
    wait_idle("t5a");

    // 5b: reset in the GAP after idx 1
    wr(1, 8, 1); wr(2, 0, 0);
    push_run(5, 7, 0); push_run(8, 3, 1);
    pulse_start();
    wait_tone_idx("t5_reach_idx1", 1);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus.tone_en) begin ok = 1; break; end
    end
    chk("t5_reach_gap", int'(ok), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_div", int'(bus.div), 0);
    chk("t5_rst_tone", int'(bus.tone_en), 0);
    chk("t5_rst_busy", int'(bus.busy), 0);
    chk("t5_rst_idx", int'(bus.note_idx), 0);
    chk("t5_rst_done", int'(bus.done), 0);
    repeat (12) @(negedge clk);
    wait_idle("t5b");

`ifdef MELODY_SEQ_LOOP_EN
    // 6: loop twice, then drop loop for a final pass ending in done
    wr(0, 12, 1); wr(1, 0, 0);
    push_run(12, 3, 0); push_run(12, 3, 0); push_run(12, 3, 0);
    push_done(1, 27);
    bus.loop = 1'b1;
    base = run_cnt;
    pulse_start();
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (run_cnt >= base + 2) begin ok = 1; break; end
    end
    chk("t6_two_loops", int'(ok), 1);
    bus.loop = 1'b0;
    wait_idle("t6");
`else
    base = run_cnt;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
